hmac_sched: RTL and testbench
=============================

HMAC_SCHED -- requirements
Module: hmac_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 4096, max cycles waited for done before abort.
REQ-002 Port clk  input  1  single clock, all logic rising-edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port cfg_challenge  input  704  PUF challenge, sampled at keygen start.
REQ-005 Port cfg_rekey  input  1  one-cycle pulse requesting key regeneration.
REQ-006 Port req_valid  input  2  per-requester job request, held until granted.
REQ-007 Port req_grant  output  2  one-hot grant, high for the whole job.
REQ-008 Port req_word  input  64  message words, requester i on bits [32*i+31:32*i].
REQ-009 Port req_wvalid  input  2  per-requester word valid.
REQ-010 Port req_wlast  input  2  per-requester last-word flag.
REQ-011 Port req_wready  output  2  per-requester word ready.
REQ-012 Port res_valid  output  2  one-cycle result pulse to requester i.
REQ-013 Port res_data  output  512  captured HMAC value, held until next result.
REQ-014 Port res_timeout  output  1  qualifies res_valid: job aborted on timeout.
REQ-015 Port key_ready  output  1  valid PUF key present in datapath.
REQ-016 Port busy  output  1  FSM not in IDLE.
REQ-017 Ports to HMAC datapath: start_puf out 1, start_hmac out 1, puf_input out 704, msg_word out 32, msg_valid out 1, msg_last out 1, msg_ready in 1, hmac_value in 512, done in 1.

Function
REQ-018 FSM states: IDLE, KEYGEN, KEYWAIT, ARB, START, STREAM, HWAIT, RESP.
REQ-019 IDLE: if key_ready=0 or rekey_pend=1 -> KEYGEN; else if any req_valid -> ARB.
REQ-020 KEYGEN: puf_input <= cfg_challenge, start_puf high exactly one cycle, -> KEYWAIT.
REQ-021 KEYWAIT: done=1 -> key_ready<=1, rekey_pend<=0, -> IDLE; timeout -> key_ready<=0, -> IDLE (retry).
REQ-022 cfg_rekey in any state sets rekey_pend; serviced only from IDLE, never aborting a running job.
REQ-023 ARB: round-robin over req_valid; when both valid, grant the requester not served last; pointer after reset favours requester 0; -> START.
REQ-024 START: start_hmac high exactly one cycle, -> STREAM.
REQ-025 STREAM: msg_word/msg_valid/msg_last combinationally from granted requester; req_wready[g]=msg_ready; ungranted wready=0; msg_valid=0 outside STREAM.
REQ-026 Beat transfers when msg_valid&msg_ready; transfer with msg_last=1 -> HWAIT; zero-word jobs unsupported.
REQ-027 HWAIT: done=1 -> res_data<=hmac_value, res_timeout<=0, -> RESP; timeout -> res_timeout<=1, res_data unchanged, -> RESP.
REQ-028 RESP: res_valid[g] high one cycle, grant dropped, pointer updated, -> IDLE.
REQ-029 Timeout counter clears on entry to KEYWAIT/HWAIT, increments each cycle there; timeout when count reaches TIMEOUT_CYC-1 with done=0; done on that same cycle wins.
REQ-030 done outside KEYWAIT/HWAIT is ignored.
REQ-031 Minimum job latency from grant to res_valid: 3 + words + datapath done latency cycles.

Reset
REQ-032 reset sets: state IDLE, req_grant 0, req_wready 0, res_valid 0, res_data 0, res_timeout 0, key_ready 0, busy 0, start_puf 0, start_hmac 0, msg_valid 0, msg_last 0, msg_word 0, puf_input 0, rekey_pend 0, rr pointer to requester 0, counter 0.
REQ-033 reset mid-job abandons job with no res_valid; first post-reset action is KEYGEN.

Structure
REQ-034 Shared package hmac_pkg holds state enum, PUF_W=704, KEY_W=512, WORD_W=32, NREQ=2.
REQ-035 Round-robin grant logic in sub-module hmac_rr_arb (req, ptr -> one-hot grant).

Verification
REQ-036 Reset release, model done 10 cycles after start_puf -> one start_puf pulse, key_ready=1, no start_hmac.
REQ-037 Requester 0 sends DEADBEEF, CAFEBABE, 00000011(last) -> start_hmac once, 3 beats forwarded in order, res_valid[0] pulse, res_data=model hmac_value, res_timeout=0.
REQ-038 Both req_valid together, 1-word jobs, repeated twice -> grant order 0,1,0,1.
REQ-039 Model never asserts done, TIMEOUT_CYC=16 -> res_valid with res_timeout=1 exactly 16 cycles after HWAIT entry, FSM returns IDLE.
REQ-040 cfg_rekey pulsed during STREAM -> job completes normally, then start_puf issued before next grant.
REQ-041 msg_ready toggled 1/0 every cycle during 4-word job -> exactly 4 beats, no duplicate or dropped word.

Source files
------------

// File: rtl/hmac_pkg.sv
// Shared sizes, FSM state type and small helpers for the HMAC job scheduler.
package hmac_pkg;

    localparam int PUF_W  = 704;
    localparam int KEY_W  = 512;
    localparam int WORD_W = 32;
    localparam int NREQ   = 2;
    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        KEYGEN,
        KEYWAIT,
        ARB,
        START,
        STREAM,
        HWAIT,
        RESP
    } state_t;

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

    // Round-robin successor; the requester after the one just served gets first pick.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (int'(p) == NREQ - 1) ? '0 : p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/hmac_rr_arb.sv
// Rotating-priority arbiter: the requester at ptr has highest priority, then ptr+1, ...
// NREQ is a power of two, so the priority index wraps naturally in PTR_W bits.
module hmac_rr_arb
    import hmac_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        idx   = '0;
        // Walk from lowest priority to highest so the closest-to-ptr request overwrites.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + PTR_W'(k);
            if (req[idx]) begin
                grant = NREQ'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/hmac_sched.sv
// Scheduler between NREQ message requesters and one PUF-keyed HMAC datapath: generates the key
// on demand, arbitrates jobs round-robin and bounds every datapath wait with a timeout.
module hmac_sched
    import hmac_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PUF_W-1:0]         cfg_challenge,
    input  logic                     cfg_rekey,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_grant,
    input  logic [NREQ*WORD_W-1:0]   req_word,
    input  logic [NREQ-1:0]          req_wvalid,
    input  logic [NREQ-1:0]          req_wlast,
    output logic [NREQ-1:0]          req_wready,
    output logic [NREQ-1:0]          res_valid,
    output logic [KEY_W-1:0]         res_data,
    output logic                     res_timeout,
    output logic                     key_ready,
    output logic                     busy,
    output logic                     start_puf,
    output logic                     start_hmac,
    output logic [PUF_W-1:0]         puf_input,
    output logic [WORD_W-1:0]        msg_word,
    output logic                     msg_valid,
    output logic                     msg_last,
    input  logic                     msg_ready,
    input  logic [KEY_W-1:0]         hmac_value,
    input  logic                     done,
    output state_t                   dbg_state
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    state_t           state;
    state_t           state_nxt;
    logic             rekey_pend;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gidx;
    logic [NREQ-1:0]  arb_grant;
    logic [CW-1:0]    cnt;
    logic             tmo;
    logic             in_stream;
    logic             in_wait;
    logic             beat;
    logic [WORD_W-1:0] sel_word;

    hmac_rr_arb u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (arb_grant)
    );

    // Requester-side and datapath-side handshakes are both valid/ready: a beat moves on a rising
    // clk edge where valid and ready are both high; valid never waits on ready, and the scheduler
    // only forwards msg_ready to the granted requester while in STREAM.
    assign in_stream = (state == STREAM);
    assign in_wait   = (state == KEYWAIT) || (state == HWAIT);
    assign tmo       = (cnt == CW'(TIMEOUT_CYC - 1)) && !done;

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == PTR_W'(i)) sel_word = req_word[i*WORD_W +: WORD_W];
        end
    end

    assign msg_valid  = in_stream & req_wvalid[gidx];
    assign msg_last   = in_stream & req_wlast[gidx];
    assign msg_word   = in_stream ? sel_word : '0;
    assign req_wready = in_stream ? (req_grant & {NREQ{msg_ready}}) : '0;
    assign beat       = msg_valid & msg_ready;

    assign start_puf  = (state == KEYGEN);
    assign start_hmac = (state == START);
    assign res_valid  = (state == RESP) ? req_grant : '0;
    assign busy       = (state != IDLE);
    assign dbg_state  = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!key_ready || rekey_pend) state_nxt = KEYGEN;
                else if (|req_valid)          state_nxt = ARB;
            end
            KEYGEN:  state_nxt = KEYWAIT;
            KEYWAIT: if (done || tmo) state_nxt = IDLE;
            // A request withdrawn before arbitration simply returns to IDLE.
            ARB:     state_nxt = (|arb_grant) ? START : IDLE;
            START:   state_nxt = STREAM;
            STREAM:  if (beat && msg_last) state_nxt = HWAIT;
            HWAIT:   if (done || tmo) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rekey_pend  <= 1'b0;
            key_ready   <= 1'b0;
            puf_input   <= '0;
            req_grant   <= '0;
            gidx        <= '0;
            ptr         <= '0;
            cnt         <= '0;
            res_data    <= '0;
            res_timeout <= 1'b0;
        end else begin
            state <= state_nxt;

            // A new rekey request arriving with a completing keygen must still be honoured.
            if (cfg_rekey)                   rekey_pend <= 1'b1;
            else if (state == KEYWAIT && done) rekey_pend <= 1'b0;

            if (state == IDLE && state_nxt == KEYGEN) puf_input <= cfg_challenge;

            if (state == KEYWAIT) begin
                if (done)     key_ready <= 1'b1;
                else if (tmo) key_ready <= 1'b0;
            end

            if (state_nxt != state && (state_nxt == KEYWAIT || state_nxt == HWAIT)) cnt <= '0;
            else if (in_wait)                                                    cnt <= cnt + CW'(1);

            if (state == ARB && (|arb_grant)) begin
                req_grant <= arb_grant;
                gidx      <= onehot_to_idx(arb_grant);
            end

            if (state == HWAIT) begin
                if (done) begin
                    res_data    <= hmac_value;
                    res_timeout <= 1'b0;
                end else if (tmo) begin
                    res_timeout <= 1'b1;
                end
            end

            if (state == RESP) begin
                req_grant <= '0;
                ptr       <= next_ptr(gidx);
            end
        end
    end

endmodule

// File: tb/tb_hmac_sched.sv
// Self-checking bench for hmac_sched: a behavioural datapath stub plus per-feature test tasks.
module tb_hmac_sched;
    import hmac_pkg::*;

    localparam int TMO      = 16;
    localparam int PUF_LAT  = 10;
    localparam int HMAC_LAT = 4;
    localparam logic [511:0] SEED = {16{32'h9e3779b9}};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [PUF_W-1:0]       cfg_challenge = '0;
    logic                   cfg_rekey = 1'b0;
    logic [1:0]             req_valid = '0;
    logic [1:0]             req_grant;
    logic [63:0]            req_word = '0;
    logic [1:0]             req_wvalid = '0;
    logic [1:0]             req_wlast = '0;
    logic [1:0]             req_wready;
    logic [1:0]             res_valid;
    logic [511:0]           res_data;
    logic                   res_timeout;
    logic                   key_ready;
    logic                   busy;
    logic                   start_puf;
    logic                   start_hmac;
    logic [PUF_W-1:0]       puf_input;
    logic [31:0]            msg_word;
    logic                   msg_valid;
    logic                   msg_last;
    logic                   msg_ready = 1'b1;
    logic [511:0]           hmac_value = '0;
    logic                   done = 1'b0;
    state_t                 dbg_state;

    hmac_sched #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .cfg_challenge(cfg_challenge), .cfg_rekey(cfg_rekey),
        .req_valid(req_valid), .req_grant(req_grant), .req_word(req_word),
        .req_wvalid(req_wvalid), .req_wlast(req_wlast), .req_wready(req_wready),
        .res_valid(res_valid), .res_data(res_data), .res_timeout(res_timeout),
        .key_ready(key_ready), .busy(busy), .start_puf(start_puf), .start_hmac(start_hmac),
        .puf_input(puf_input), .msg_word(msg_word), .msg_valid(msg_valid), .msg_last(msg_last),
        .msg_ready(msg_ready), .hmac_value(hmac_value), .done(done), .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;

    // ---------------- datapath stub / monitor ----------------
    logic dp_respond = 1'b1;
    logic ready_toggle = 1'b0;
    int   stray_req = 0;
    int   stray_seen = 0;
    int   puf_timer = 0, hmac_timer = 0;
    logic [511:0] acc = '0, pend_value = '0;
    logic [31:0] got_q[$];
    int   n_puf = 0, n_hmac = 0, n_res = 0, n_beats = 0;
    int   puf_cyc = 0, grant_cyc = 0, res_cyc = 0, beat_cyc = 0, key_cyc = 0;
    logic [1:0]   prev_grant = '0;
    logic         prev_key = 1'b0;
    logic [1:0]   res_who = '0;
    logic [511:0] res_data_s = '0;
    logic         res_tmo_s = 1'b0;
    logic [31:0]  exp_q[$];

    function automatic logic [511:0] fold(input logic [511:0] a, input logic [31:0] w);
        return {a[479:0], a[511:480] ^ w};
    endfunction

    initial begin : dp_stub
        forever begin
            @(negedge clk);
            if (reset) begin
                puf_timer  = 0;
                hmac_timer = 0;
            end else begin
                if (start_puf) begin
                    n_puf++;
                    puf_cyc = cyc;
                    if (dp_respond) puf_timer = PUF_LAT;
                end
                if (start_hmac) begin
                    n_hmac++;
                    acc = SEED;
                    got_q.delete();
                end
                if (msg_valid && msg_ready) begin
                    got_q.push_back(msg_word);
                    acc = fold(acc, msg_word);
                    n_beats++;
                    beat_cyc = cyc;
                    if (msg_last && dp_respond) begin
                        hmac_timer = HMAC_LAT;
                        pend_value = acc;
                    end
                end
                if (|res_valid) begin
                    n_res++;
                    res_cyc    = cyc;
                    res_who    = res_valid;
                    res_data_s = res_data;
                    res_tmo_s  = res_timeout;
                end
                if (req_grant != 2'b00 && prev_grant == 2'b00) grant_cyc = cyc;
                if (key_ready && !prev_key) key_cyc = cyc;
            end
            prev_grant = req_grant;
            prev_key   = key_ready;
            @(posedge clk);
            #1;
            done = 1'b0;
            if (puf_timer > 0) begin
                puf_timer--;
                if (puf_timer == 0) done = 1'b1;
            end
            if (hmac_timer > 0) begin
                hmac_timer--;
                if (hmac_timer == 0) begin
                    done = 1'b1;
                    hmac_value = pend_value;
                end
            end
            if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                done = 1'b1;
                hmac_value = ~hmac_value;
            end
            msg_ready = ready_toggle ? ~msg_ready : 1'b1;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic do_job(input int r, input int n, input logic [31:0] w [8]);
        int guard;
        @(posedge clk); #1;
        req_valid[r] = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!req_grant[r] && guard < 200);
        if (!req_grant[r]) begin
            checks++; failures++;
            $display("FAIL grant_wait: requester %0d got no grant, grant=%b expected bit %0d", r, req_grant, r);
            req_valid[r] = 1'b0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req_valid[r] = 1'b0;
            req_word[32*r +: 32] = w[i];
            req_wvalid[r] = 1'b1;
            req_wlast[r]  = (i == n - 1);
            guard = 0;
            do begin @(negedge clk); guard++; end while (!req_wready[r] && guard < 50);
            if (!req_wready[r]) begin
                checks++; failures++;
                $display("FAIL wready_wait: requester %0d word %0d never accepted, wready=%b", r, i, req_wready);
                req_wvalid[r] = 1'b0;
                req_wlast[r] = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        req_wvalid[r] = 1'b0;
        req_wlast[r]  = 1'b0;
    endtask

    task automatic wait_res(input int n0);
        int guard;
        guard = 0;
        while (n_res <= n0 && guard < 100) begin @(negedge clk); guard++; end
        if (n_res <= n0) begin
            checks++; failures++;
            $display("FAIL res_wait: no res_valid within budget, n_res=%0d required>%0d", n_res, n0);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_grant, req_wready, res_valid, res_timeout, key_ready, busy, start_puf, start_hmac,
             msg_valid, msg_last} !== 14'b0) begin
            failures++;
            $display("FAIL reset_ctrl: grant=%b wready=%b resv=%b tmo=%b key=%b busy=%b spuf=%b shmac=%b mv=%b ml=%b, required all 0",
                     req_grant, req_wready, res_valid, res_timeout, key_ready, busy, start_puf, start_hmac, msg_valid, msg_last);
        end
        checks++;
        if (res_data !== '0 || msg_word !== '0 || puf_input !== '0) begin
            failures++;
            $display("FAIL reset_data: res_data=%h msg_word=%h puf_input=%h, required 0", res_data, msg_word, puf_input);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_state: state=%0d required IDLE", dbg_state);
        end
    endtask

    task automatic test_keygen();
        logic [PUF_W-1:0] chal;
        int rel, n_puf0, n_hmac0, guard;
        for (int i = 0; i < PUF_W / 32; i++) chal[32*i +: 32] = $urandom();
        cfg_challenge = chal;
        n_puf0 = n_puf; n_hmac0 = n_hmac;
        @(posedge clk); #1;
        reset = 1'b0;
        rel = cyc;
        guard = 0;
        while (!key_ready && guard < 60) begin @(negedge clk); guard++; end
        repeat (3) @(negedge clk);
        checks++;
        if (key_ready !== 1'b1) begin failures++; $display("FAIL keygen_ready: key_ready=%b required 1", key_ready); end
        checks++;
        if (n_puf - n_puf0 != 1) begin failures++; $display("FAIL keygen_pulses: start_puf cycles=%0d required 1", n_puf - n_puf0); end
        checks++;
        if (n_hmac != n_hmac0) begin failures++; $display("FAIL keygen_hmac: start_hmac cycles=%0d required 0", n_hmac - n_hmac0); end
        checks++;
        if (puf_cyc != rel + 1) begin failures++; $display("FAIL keygen_first: start_puf at cycle %0d required %0d", puf_cyc, rel + 1); end
        checks++;
        if (key_cyc - puf_cyc != PUF_LAT + 1) begin failures++; $display("FAIL keygen_lat: key_ready after %0d cycles required %0d", key_cyc - puf_cyc, PUF_LAT + 1); end
        checks++;
        if (puf_input !== chal) begin failures++; $display("FAIL keygen_chal: puf_input=%h required %h", puf_input, chal); end
    endtask

    task automatic test_single_job();
        logic [31:0] w [8];
        logic [511:0] exp_d;
        logic [31:0] e;
        int n_res0, n_hmac0;
        w = '{32'hDEADBEEF, 32'hCAFEBABE, 32'h00000011, 0, 0, 0, 0, 0};
        exp_d = SEED;
        for (int i = 0; i < 3; i++) begin exp_q.push_back(w[i]); exp_d = fold(exp_d, w[i]); end
        n_res0 = n_res; n_hmac0 = n_hmac;
        do_job(0, 3, w);
        wait_res(n_res0);
        @(negedge clk);
        checks++;
        if (n_hmac - n_hmac0 != 1) begin failures++; $display("FAIL job_start: start_hmac cycles=%0d required 1", n_hmac - n_hmac0); end
        checks++;
        if (got_q.size() != 3) begin failures++; $display("FAIL job_beats: beats=%0d required 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q[i] !== e) begin failures++; $display("FAIL job_word%0d: got %h required %h", i, got_q[i], e); end
        end
        exp_q.delete();
        checks++;
        if (res_who !== 2'b01 || res_tmo_s !== 1'b0) begin
            failures++; $display("FAIL job_res: res_valid=%b timeout=%b required 01/0", res_who, res_tmo_s);
        end
        checks++;
        if (res_data_s !== exp_d) begin failures++; $display("FAIL job_data: res_data=%h required %h", res_data_s, exp_d); end
        checks++;
        if (res_cyc - beat_cyc != HMAC_LAT + 1) begin failures++; $display("FAIL job_lat: res after %0d cycles required %0d", res_cyc - beat_cyc, HMAC_LAT + 1); end
        checks++;
        if (n_res - n_res0 != 1 || req_grant !== 2'b00 || busy !== 1'b0) begin
            failures++; $display("FAIL job_end: pulses=%0d grant=%b busy=%b required 1/00/0", n_res - n_res0, req_grant, busy);
        end
    endtask

    task automatic test_reset_midjob();
        int n_res0, n_hmac0, rel, guard;
        @(posedge clk); #1;
        req_valid[1] = 1'b1;
        guard = 0;
        do begin @(negedge clk); guard++; end while (!req_grant[1] && guard < 50);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        req_word[63:32] = $urandom();
        req_wvalid[1] = 1'b1;
        req_wlast[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_res0 = n_res;
        reset = 1'b1;
        req_wvalid = '0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_grant !== 2'b00 || busy !== 1'b0 || key_ready !== 1'b0) begin
            failures++; $display("FAIL midjob_reset: grant=%b busy=%b key=%b required 00/0/0", req_grant, busy, key_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        rel = cyc;
        n_hmac0 = n_hmac;
        guard = 0;
        while (!key_ready && guard < 60) begin @(negedge clk); guard++; end
        checks++;
        if (n_res != n_res0) begin failures++; $display("FAIL midjob_nores: res pulses=%0d required 0", n_res - n_res0); end
        checks++;
        if (puf_cyc != rel + 1 || n_hmac != n_hmac0 || key_ready !== 1'b1) begin
            failures++; $display("FAIL midjob_keygen: puf at %0d required %0d, hmac=%0d required 0, key=%b", puf_cyc, rel + 1, n_hmac - n_hmac0, key_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [2][2];
        int left [2];
        int last_served, exp_g, g, guard, n_res0;
        logic [31:0] word;
        for (int r = 0; r < 2; r++) for (int j = 0; j < 2; j++) w[r][j] = $urandom();
        left = '{2, 2};
        last_served = -1;
        @(posedge clk); #1;
        req_valid = 2'b11;
        for (int job = 0; job < 4; job++) begin
            if (left[0] > 0 && left[1] > 0) exp_g = (last_served == 0) ? 1 : 0;
            else                            exp_g = (left[0] > 0) ? 0 : 1;
            n_res0 = n_res;
            guard = 0;
            do begin @(negedge clk); guard++; end while (req_grant == 2'b00 && guard < 100);
            checks++;
            if (req_grant !== (2'b01 << exp_g)) begin
                failures++; $display("FAIL rr_grant%0d: grant=%b required %b", job, req_grant, 2'b01 << exp_g);
            end
            if (req_grant == 2'b00) return;
            g = req_grant[1] ? 1 : 0;
            word = w[g][2 - left[g]];
            @(posedge clk); #1;
            req_valid[g] = 1'b0;
            req_word[32*g +: 32] = word;
            req_wvalid[g] = 1'b1;
            req_wlast[g] = 1'b1;
            guard = 0;
            do begin @(negedge clk); guard++; end while (!req_wready[g] && guard < 50);
            @(posedge clk); #1;
            req_wvalid[g] = 1'b0;
            req_wlast[g] = 1'b0;
            wait_res(n_res0);
            checks++;
            if (res_who !== (2'b01 << g) || res_data_s !== fold(SEED, word)) begin
                failures++; $display("FAIL rr_res%0d: res_valid=%b data=%h required %b/%h", job, res_who, res_data_s, 2'b01 << g, fold(SEED, word));
            end
            left[g]--;
            last_served = g;
            @(posedge clk); #1;
            if (left[g] > 0) req_valid[g] = 1'b1;
        end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        logic [31:0] w [8];
        logic [511:0] prev_data;
        int n_res0;
        for (int i = 0; i < 8; i++) w[i] = $urandom();
        prev_data = res_data;
        dp_respond = 1'b0;
        n_res0 = n_res;
        do_job(1, 2, w);
        wait_res(n_res0);
        @(negedge clk);
        dp_respond = 1'b1;
        checks++;
        if (res_tmo_s !== 1'b1 || res_who !== 2'b10) begin
            failures++; $display("FAIL tmo_flag: timeout=%b res_valid=%b required 1/10", res_tmo_s, res_who);
        end
        checks++;
        if (res_cyc - beat_cyc != TMO + 1) begin
            failures++; $display("FAIL tmo_lat: res %0d cycles after HWAIT entry required %0d", res_cyc - beat_cyc - 1, TMO);
        end
        checks++;
        if (res_data_s !== prev_data) begin failures++; $display("FAIL tmo_data: res_data=%h required unchanged %h", res_data_s, prev_data); end
        checks++;
        if (dbg_state !== IDLE || busy !== 1'b0 || key_ready !== 1'b1) begin
            failures++; $display("FAIL tmo_idle: state=%0d busy=%b key=%b required IDLE/0/1", dbg_state, busy, key_ready);
        end
    endtask

    task automatic test_rekey();
        logic [31:0] w [8];
        logic [31:0] w2 [8];
        logic [511:0] exp_d;
        int n_res0, n_puf0, n_beats0, guard;
        state_t st_at_pulse;
        for (int i = 0; i < 8; i++) begin w[i] = $urandom(); w2[i] = $urandom(); end
        exp_d = SEED;
        for (int i = 0; i < 4; i++) exp_d = fold(exp_d, w[i]);
        n_res0 = n_res; n_puf0 = n_puf; n_beats0 = n_beats;
        st_at_pulse = IDLE;
        fork
            do_job(0, 4, w);
            begin
                guard = 0;
                while (n_beats < n_beats0 + 1 && guard < 100) begin @(negedge clk); guard++; end
                @(posedge clk); #1;
                cfg_rekey = 1'b1;
                @(negedge clk);
                st_at_pulse = dbg_state;
                @(posedge clk); #1;
                cfg_rekey = 1'b0;
            end
        join
        wait_res(n_res0);
        checks++;
        if (st_at_pulse !== STREAM) begin failures++; $display("FAIL rekey_when: state at pulse=%0d required STREAM", st_at_pulse); end
        checks++;
        if (res_tmo_s !== 1'b0 || res_data_s !== exp_d || n_puf != n_puf0) begin
            failures++; $display("FAIL rekey_job: timeout=%b data=%h puf_pulses=%0d required 0/%h/0", res_tmo_s, res_data_s, n_puf - n_puf0, exp_d);
        end
        n_res0 = n_res;
        do_job(1, 1, w2);
        wait_res(n_res0);
        checks++;
        if (n_puf - n_puf0 != 1 || !(puf_cyc < grant_cyc)) begin
            failures++; $display("FAIL rekey_order: puf_pulses=%0d puf_cyc=%0d grant_cyc=%0d required 1 and puf before grant", n_puf - n_puf0, puf_cyc, grant_cyc);
        end
        checks++;
        if (res_data_s !== fold(SEED, w2[0]) || key_ready !== 1'b1) begin
            failures++; $display("FAIL rekey_next: data=%h key=%b required %h/1", res_data_s, key_ready, fold(SEED, w2[0]));
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [8];
        logic [511:0] exp_d;
        logic [31:0] e;
        int n_res0, n_beats0;
        for (int i = 0; i < 8; i++) w[i] = $urandom();
        exp_d = SEED;
        for (int i = 0; i < 4; i++) begin exp_q.push_back(w[i]); exp_d = fold(exp_d, w[i]); end
        ready_toggle = 1'b1;
        n_res0 = n_res; n_beats0 = n_beats;
        do_job(1, 4, w);
        wait_res(n_res0);
        ready_toggle = 1'b0;
        checks++;
        if (n_beats - n_beats0 != 4 || got_q.size() != 4) begin
            failures++; $display("FAIL bp_beats: beats=%0d queued=%0d required 4", n_beats - n_beats0, got_q.size());
        end
        for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q[i] !== e) begin failures++; $display("FAIL bp_word%0d: got %h required %h", i, got_q[i], e); end
        end
        exp_q.delete();
        checks++;
        if (res_data_s !== exp_d || res_who !== 2'b10) begin
            failures++; $display("FAIL bp_data: data=%h res_valid=%b required %h/10", res_data_s, res_who, exp_d);
        end
    endtask

    task automatic test_stray_done();
        logic [511:0] d0;
        int n_res0;
        repeat (2) @(negedge clk);
        d0 = res_data;
        n_res0 = n_res;
        stray_req++;
        repeat (4) @(negedge clk);
        checks++;
        if (dbg_state !== IDLE || n_res != n_res0 || res_data !== d0 || key_ready !== 1'b1) begin
            failures++; $display("FAIL stray_done: state=%0d pulses=%0d data=%h key=%b required IDLE/0/%h/1", dbg_state, n_res - n_res0, res_data, key_ready, d0);
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin : main
        test_reset();
        test_keygen();
        test_single_job();
        test_stray_done();
        test_reset_midjob();
        test_back_to_back();
        test_timeout();
        test_rekey();
        test_backpressure();
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
